lsu_rmw: RTL and testbench
==========================

Name: lsu_rmw

Overview:
- Load/store unit between the core's execute stage and the word-only data memory.
- The memory has an async read, a sync 32-bit write and word addressing on addr[31:2]. It has no byte enables.
- This block issues word accesses to it, extracts and sign-extends sub-word loads, and performs a read-modify-write for byte and halfword stores.
- It also flags misaligned, out-of-range and illegal accesses, and stalls the core through a ready/done handshake.

Parameters:
- BYTES, 2048, data memory size in bytes. Must match the memory instance. Addresses >= BYTES are out of range.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req  in  1  access request; sampled only when o_ready=1
- i_is_store  in  1  1=store, 0=load
- i_funct3  in  3  RV32I size/sign: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu
- i_addr  in  32  byte address
- i_wdata  in  32  store data, right-aligned
- o_ready  out  1  high in IDLE; an accepting cycle is i_req&o_ready
- o_done  out  1  one-cycle completion pulse
- o_ld_data  out  32  extended load result; valid while o_done=1
- o_exc  out  1  pulses with o_done on a rejected access
- o_mem_re  out  1  memory read enable
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  32  word-aligned byte address ({addr[31:2],2'b00})
- o_mem_wdata  out  32  full word to write
- i_mem_rdata  in  32  combinational read data from memory

Behaviour:
- Reset (async, active-low):
  - State goes to IDLE.
  - o_done, o_exc, o_mem_re and o_mem_we go to 0.
  - o_ld_data, o_mem_addr and o_mem_wdata go to 0.
  - o_ready is 1 after reset releases.
  - Reset asserted in WRITE aborts the write; o_mem_we drops immediately and no partial word is written.
- States: IDLE, WRITE, RESP. Encoding lives in the package.
- IDLE, o_ready=1, no request: memory outputs are 0.
- IDLE, request accepted: the request is checked first.
  - Rejection causes:
    - Illegal funct3 (011, 110, 111).
    - Store with funct3=100/101.
    - Misaligned half: addr[0]=1.
    - Misaligned word: addr[1:0]!=0.
    - addr >= BYTES.
  - On rejection: no memory enable; o_exc is set for the RESP cycle; o_ld_data=0; go to RESP.
  - Valid load: o_mem_re=1 in the accept cycle. Register extract(i_mem_rdata, addr[1:0], funct3) into o_ld_data. Go to RESP.
    - Byte lane = addr[1:0] (little-endian). Half lane = addr[1].
    - lb/lh sign-extend; lbu/lhu zero-extend.
  - Valid sw: o_mem_we=1 and o_mem_wdata=i_wdata in the accept cycle. Go to RESP.
  - Valid sb/sh: o_mem_re=1 in the accept cycle. Register merge(i_mem_rdata, i_wdata, lane, size) into the write buffer and latch the word address. Go to WRITE.
- WRITE: o_mem_we=1 with the latched address and the write buffer; o_mem_re=0. Go to RESP.
- RESP: o_done=1, o_ready=0; o_exc as latched. Go to IDLE. o_ld_data holds until the next load completes.
- Latency, accept to o_done:
  - Load, sw and rejected access: 1 cycle.
  - sb/sh: 2 cycles.
- Throughput: next accept is the cycle after o_done. Back-to-back accesses are never merged.
- i_req while o_ready=0 is ignored. The core holds the request, or drops it; dropping is legal.
- Memory-side outputs are driven combinationally from state and latched/current request fields. There are no glitches on o_mem_we outside the accept cycle (sw) or the WRITE state.

Decomposition:
- Package lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum lsu_state_e.
  - Lane/size helper typedef.
- Sub-module lsu_align: purely combinational extract (load path) and merge (store path). This lets each path be unit-tested alone.
- lsu_rmw holds the FSM, request latches and error checks.

Test Plan:
- sw 0x11223344 @0x10, then lw @0x10 -> o_done 1 cycle after each accept; o_ld_data=0x11223344; one cycle of o_mem_we.
- sb 0x80 @0x11 -> o_mem_re in accept cycle, o_mem_we in next cycle with wdata 0x11228044, o_done at +2. Then:
  - lb @0x11 -> 0xFFFFFF80.
  - lbu @0x11 -> 0x00000080.
  - lb @0x13 -> 0x00000011.
- sh 0xBEEF @0x12 -> word becomes 0xBEEF8044. lh @0x12 -> 0xFFFFBEEF; lhu -> 0x0000BEEF.
- Each of the following -> o_exc=1 with o_done, no o_mem_we/o_mem_re, memory unchanged:
  - lw @0x12.
  - sh @0x13.
  - sw @BYTES (0x800).
  - funct3=011.
  - store with funct3=100.
- Reset: sb accepted, i_rst_n low during WRITE -> o_mem_we low same cycle, word unchanged, o_ready=1 after release, no o_done.
- Handshake: i_req held high continuously over 3 stores -> exactly 3 accepts, each only when o_ready=1; no duplicate writes; final memory state correct.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: RV32I size codes, FSM states and
// the lane/size descriptor passed between the control FSM and the aligner.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_RESP  = 2'd2
   } lsu_state_e;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } lsu_size_e;

   typedef struct packed {
      logic [1:0] lane;
      lsu_size_e  size;
      logic       uns;
   } lsu_access_t;

   // Unknown size codes decode as word; the FSM rejects them separately.
   function automatic lsu_access_t decode_access(input logic [2:0] f3, input logic [1:0] lane);
      lsu_access_t acc;
      acc.lane = lane;
      acc.uns  = f3[2];
      case (f3[1:0])
         2'b00:   acc.size = SZ_B;
         2'b01:   acc.size = SZ_H;
         default: acc.size = SZ_W;
      endcase
      return acc;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data aligner: extracts and extends sub-word loads from a
// memory word, and merges sub-word store data into a memory word.
module lsu_align
   import lsu_pkg::*;
(
   input  lsu_access_t i_acc,
   input  logic [31:0] i_rdata,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_ld_data,
   output logic [31:0] o_merged
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Load path: select the addressed lane, then sign- or zero-extend.
   always_comb begin
      case (i_acc.lane)
         2'd0:    byte_s = i_rdata[7:0];
         2'd1:    byte_s = i_rdata[15:8];
         2'd2:    byte_s = i_rdata[23:16];
         2'd3:    byte_s = i_rdata[31:24];
         default: byte_s = i_rdata[7:0];
      endcase
      if (i_acc.lane[1]) begin
         half_s = i_rdata[31:16];
      end else begin
         half_s = i_rdata[15:0];
      end
      case (i_acc.size)
         SZ_B:    o_ld_data = i_acc.uns ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
         SZ_H:    o_ld_data = i_acc.uns ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
         SZ_W:    o_ld_data = i_rdata;
         default: o_ld_data = i_rdata;
      endcase
   end

   // Store path: overwrite only the addressed lane of the old word.
   always_comb begin
      o_merged = i_rdata;
      case (i_acc.size)
         SZ_B: begin
            case (i_acc.lane)
               2'd0:    o_merged[7:0]   = i_wdata[7:0];
               2'd1:    o_merged[15:8]  = i_wdata[7:0];
               2'd2:    o_merged[23:16] = i_wdata[7:0];
               2'd3:    o_merged[31:24] = i_wdata[7:0];
               default: o_merged        = i_rdata;
            endcase
         end
         SZ_H: begin
            if (i_acc.lane[1]) begin
               o_merged[31:16] = i_wdata[15:0];
            end else begin
               o_merged[15:0]  = i_wdata[15:0];
            end
         end
         SZ_W:    o_merged = i_wdata;
         default: o_merged = i_rdata;
      endcase
   end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit for a word-only memory: sub-word loads are extracted in
// the read cycle, sub-word stores become a read-modify-write.
module lsu_rmw
   import lsu_pkg::*;
#(
   parameter int unsigned BYTES = 2048
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req,
   input  logic        i_is_store,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic        o_ready,
   output logic        o_done,
   output logic [31:0] o_ld_data,
   output logic        o_exc,
   output logic        o_mem_re,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   input  logic [31:0] i_mem_rdata
);

   lsu_state_e  state_q, state_d;
   logic        exc_q, exc_d;
   logic [31:0] ld_data_q, ld_data_d;
   logic [31:0] wbuf_q, wbuf_d;
   logic [31:0] waddr_q, waddr_d;

   lsu_access_t acc_s;
   logic        illegal_f3_s;
   logic        misalign_s;
   logic        reject_s;
   logic [31:0] word_addr_s;
   logic [31:0] extract_s;
   logic [31:0] merged_s;

   assign acc_s       = decode_access(i_funct3, i_addr[1:0]);
   assign word_addr_s = {i_addr[31:2], 2'b00};

   lsu_align u_align (
      .i_acc     (acc_s),
      .i_rdata   (i_mem_rdata),
      .i_wdata   (i_wdata),
      .o_ld_data (extract_s),
      .o_merged  (merged_s)
   );

   // Request legality checks, evaluated on the current request fields.
   always_comb begin
      case (i_funct3)
         F3_B, F3_H, F3_W, F3_BU, F3_HU: illegal_f3_s = 1'b0;
         default:                         illegal_f3_s = 1'b1;
      endcase
      misalign_s = ((acc_s.size == SZ_H) && i_addr[0]) ||
                   ((acc_s.size == SZ_W) && (i_addr[1:0] != 2'b00));
      reject_s   = illegal_f3_s || (i_is_store && i_funct3[2]) || misalign_s ||
                   (i_addr >= BYTES);
   end

   // FSM next state, request latches and memory-side outputs.
   always_comb begin
      state_d     = state_q;
      exc_d       = exc_q;
      ld_data_d   = ld_data_q;
      wbuf_d      = wbuf_q;
      waddr_d     = waddr_q;
      o_ready     = 1'b0;
      o_done      = 1'b0;
      o_exc       = 1'b0;
      o_mem_re    = 1'b0;
      o_mem_we    = 1'b0;
      o_mem_addr  = 32'h0000_0000;
      o_mem_wdata = 32'h0000_0000;
      case (state_q)
         ST_IDLE: begin
            o_ready = 1'b1;
            if (i_req) begin
               exc_d   = reject_s;
               state_d = ST_RESP;
               if (reject_s) begin
                  ld_data_d = 32'h0000_0000;
               end else if (!i_is_store) begin
                  o_mem_re   = 1'b1;
                  o_mem_addr = word_addr_s;
                  ld_data_d  = extract_s;
               end else if (acc_s.size == SZ_W) begin
                  o_mem_we    = 1'b1;
                  o_mem_addr  = word_addr_s;
                  o_mem_wdata = i_wdata;
               end else begin
                  o_mem_re   = 1'b1;
                  o_mem_addr = word_addr_s;
                  wbuf_d     = merged_s;
                  waddr_d    = word_addr_s;
                  state_d    = ST_WRITE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WRITE: begin
            o_mem_we    = 1'b1;
            o_mem_addr  = waddr_q;
            o_mem_wdata = wbuf_q;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            o_done  = 1'b1;
            o_exc   = exc_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and latch registers; reset in WRITE drops the pending write.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         exc_q     <= 1'b0;
         ld_data_q <= 32'h0000_0000;
         wbuf_q    <= 32'h0000_0000;
         waddr_q   <= 32'h0000_0000;
      end else begin
         state_q   <= state_d;
         exc_q     <= exc_d;
         ld_data_q <= ld_data_d;
         wbuf_q    <= wbuf_d;
         waddr_q   <= waddr_d;
      end
   end

   assign o_ld_data = ld_data_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw with a word memory and a transaction-level
// reference model checked every cycle.
module tb_lsu_rmw;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_req = 1'b0;
   logic        i_is_store = 1'b0;
   logic [2:0]  i_funct3 = 3'b000;
   logic [31:0] i_addr = 32'h0;
   logic [31:0] i_wdata = 32'h0;
   logic        o_ready, o_done, o_exc, o_mem_re, o_mem_we;
   logic [31:0] o_ld_data, o_mem_addr, o_mem_wdata, i_mem_rdata;

   int vectors = 0;
   int miscompares = 0;
   int we_cnt = 0;

   logic [31:0] env_mem [0:511];
   logic [31:0] ref_mem [0:511];

   always #5 clk = ~clk;

   lsu_rmw #(.BYTES(2048)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(i_req), .i_is_store(i_is_store),
      .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
      .o_ready(o_ready), .o_done(o_done), .o_ld_data(o_ld_data), .o_exc(o_exc),
      .o_mem_re(o_mem_re), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
   );

   assign i_mem_rdata = env_mem[o_mem_addr[10:2]];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory environment: async read, sync word write.
   initial begin
      for (int i = 0; i < 512; i++) begin
         env_mem[i] <= 32'h0;
         ref_mem[i] = 32'h0;
      end
      forever begin
         @(posedge clk);
         if (o_mem_we) begin
            env_mem[o_mem_addr[10:2]] <= o_mem_wdata;
            we_cnt++;
         end
      end
   end

   function automatic int sz_of(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic logic m_valid(input logic st, input logic [2:0] f3, input logic [31:0] a);
      if (!(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)) return 1'b0;
      if (st && f3[2]) return 1'b0;
      if ((a % sz_of(f3)) != 0) return 1'b0;
      if (a >= 32'd2048) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [31:0] m_mask(input int sz);
      return (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f3);
      int sz = sz_of(f3);
      logic [31:0] m = m_mask(sz);
      logic [31:0] v = (w >> (8 * (a % 4))) & m;
      if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~m;
      return v;
   endfunction

   function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [31:0] d, input logic [31:0] a, input logic [2:0] f3);
      int sh = 8 * (a % 4);
      logic [31:0] m = m_mask(sz_of(f3)) << sh;
      return (w & ~m) | ((d << sh) & m);
   endfunction

   // Reference model and per-cycle compare.
   initial begin
      int c = 0;
      int pend_done = -1;
      int pend_wr = -1;
      logic [31:0] pend_ld = 32'h0, last_ld = 32'h0;
      logic [31:0] pend_waddr = 32'h0, pend_wdata = 32'h0;
      logic        pend_exc = 1'b0;
      int          widx = 0;
      logic e_ready, e_done, e_re, e_we, e_exc, ok;
      logic [31:0] e_addr, e_wd, e_ld;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pend_done = -1;
            pend_wr = -1;
            last_ld = 32'h0;
            chk("rst_done", {31'd0, o_done}, 32'd0);
            chk("rst_exc", {31'd0, o_exc}, 32'd0);
            chk("rst_re", {31'd0, o_mem_re}, 32'd0);
            chk("rst_we", {31'd0, o_mem_we}, 32'd0);
            chk("rst_ld", o_ld_data, 32'h0);
            chk("rst_addr", o_mem_addr, 32'h0);
            chk("rst_wdata", o_mem_wdata, 32'h0);
         end else begin
            e_ready = (pend_done < 0);
            e_done  = (c == pend_done);
            e_exc   = e_done && pend_exc;
            e_ld    = e_done ? pend_ld : last_ld;
            e_re    = 1'b0;
            e_we    = (c == pend_wr);
            e_addr  = e_we ? pend_waddr : 32'h0;
            e_wd    = e_we ? pend_wdata : 32'h0;
            if (e_ready && i_req) begin
               ok = m_valid(i_is_store, i_funct3, i_addr);
               widx = int'(i_addr[10:2]);
               pend_exc = !ok;
               pend_done = c + 1;
               pend_ld = last_ld;
               if (!ok) begin
                  pend_ld = 32'h0;
               end else if (!i_is_store) begin
                  e_re = 1'b1;
                  e_addr = i_addr & ~32'd3;
                  pend_ld = m_load(ref_mem[widx], i_addr, i_funct3);
               end else if (sz_of(i_funct3) == 4) begin
                  e_we = 1'b1;
                  e_addr = i_addr & ~32'd3;
                  e_wd = i_wdata;
                  ref_mem[widx] = i_wdata;
               end else begin
                  e_re = 1'b1;
                  e_addr = i_addr & ~32'd3;
                  pend_wr = c + 1;
                  pend_waddr = e_addr;
                  pend_wdata = m_merge(ref_mem[widx], i_wdata, i_addr, i_funct3);
                  pend_done = c + 2;
               end
            end
            chk("ready", {31'd0, o_ready}, {31'd0, e_ready});
            chk("done", {31'd0, o_done}, {31'd0, e_done});
            chk("exc", {31'd0, o_exc}, {31'd0, e_exc});
            chk("mem_re", {31'd0, o_mem_re}, {31'd0, e_re});
            chk("mem_we", {31'd0, o_mem_we}, {31'd0, e_we});
            chk("ld_data", o_ld_data, e_ld);
            if (e_re || e_we) chk("mem_addr", o_mem_addr, e_addr);
            if (e_we) chk("mem_wdata", o_mem_wdata, e_wd);
            if (e_ready && !i_req) begin
               chk("idle_addr", o_mem_addr, 32'h0);
               chk("idle_wdata", o_mem_wdata, 32'h0);
            end
            if (c == pend_wr) begin
               ref_mem[pend_waddr[10:2]] = pend_wdata;
               pend_wr = -1;
            end
            if (e_done) begin
               chk("mem_word", env_mem[widx], ref_mem[widx]);
               last_ld = pend_ld;
               pend_done = -1;
            end
         end
         c++;
      end
   end

   task automatic acc(input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int lat, input logic ex,
                      input logic ck_ld, input logic [31:0] eld);
      int n;
      @(posedge clk);
      #2;
      i_req = 1'b1; i_is_store = st; i_funct3 = f3; i_addr = a; i_wdata = wd;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!o_ready && n < 20);
      chk("accept_wait", {31'd0, o_ready}, 32'd1);
      @(posedge clk);
      #2;
      i_req = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!o_done && n < 10);
      chk("latency", n, lat);
      chk("lit_exc", {31'd0, o_exc}, {31'd0, ex});
      if (ck_ld) chk("lit_ld", o_ld_data, eld);
   endtask

   initial begin
      int n, w0;
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, w0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
      chk("post_rst_ready", {31'd0, o_ready}, 32'd1);
      chk("post_rst_done", {31'd0, o_done}, 32'd0);
      chk("post_rst_ld", o_ld_data, 32'h0);

      acc(1'b1, 3'b010, 32'h10, 32'h1122_3344, 1, 1'b0, 1'b0, 32'h0);
      acc(1'b0, 3'b010, 32'h10, 32'h0, 1, 1'b0, 1'b1, 32'h1122_3344);
      acc(1'b1, 3'b000, 32'h11, 32'h80, 2, 1'b0, 1'b0, 32'h0);
      chk("lit_sb_word", env_mem[4], 32'h1122_8044);
      acc(1'b0, 3'b000, 32'h11, 32'h0, 1, 1'b0, 1'b1, 32'hFFFF_FF80);
      acc(1'b0, 3'b100, 32'h11, 32'h0, 1, 1'b0, 1'b1, 32'h0000_0080);
      acc(1'b0, 3'b000, 32'h13, 32'h0, 1, 1'b0, 1'b1, 32'h0000_0011);
      acc(1'b1, 3'b001, 32'h12, 32'hBEEF, 2, 1'b0, 1'b0, 32'h0);
      chk("lit_sh_word", env_mem[4], 32'hBEEF_8044);
      acc(1'b0, 3'b001, 32'h12, 32'h0, 1, 1'b0, 1'b1, 32'hFFFF_BEEF);
      acc(1'b0, 3'b101, 32'h12, 32'h0, 1, 1'b0, 1'b1, 32'h0000_BEEF);

      w0 = we_cnt;
      acc(1'b0, 3'b010, 32'h12, 32'h0, 1, 1'b1, 1'b1, 32'h0);
      acc(1'b1, 3'b001, 32'h13, 32'h1234, 1, 1'b1, 1'b1, 32'h0);
      acc(1'b1, 3'b010, 32'h800, 32'hDEAD_BEEF, 1, 1'b1, 1'b1, 32'h0);
      acc(1'b0, 3'b011, 32'h10, 32'h0, 1, 1'b1, 1'b1, 32'h0);
      acc(1'b1, 3'b100, 32'h10, 32'h77, 1, 1'b1, 1'b1, 32'h0);
      chk("exc_no_writes", we_cnt - w0, 32'd0);
      chk("exc_word", env_mem[4], 32'hBEEF_8044);

      // Reset while the sub-word write is pending.
      @(posedge clk);
      #2;
      i_req = 1'b1; i_is_store = 1'b1; i_funct3 = 3'b000; i_addr = 32'h20; i_wdata = 32'h55;
      @(negedge clk);
      chk("rst_accept_ready", {31'd0, o_ready}, 32'd1);
      @(posedge clk);
      #2;
      i_req = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_we_drop", {31'd0, o_mem_we}, 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_word_kept", env_mem[8], 32'h0);
      chk("rst_ready", {31'd0, o_ready}, 32'd1);

      // Request held high across three stores.
      w0 = we_cnt;
      @(posedge clk);
      #2;
      i_req = 1'b1; i_is_store = 1'b1; i_funct3 = 3'b010; i_addr = 32'h40; i_wdata = 32'hAAAA_5555;
      for (int k = 0; k < 3; k++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!o_ready && n < 20);
         chk("hold_accept", {31'd0, o_ready}, 32'd1);
         @(posedge clk);
         #2;
         if (k == 0) begin
            i_funct3 = 3'b000; i_addr = 32'h41; i_wdata = 32'h12;
         end else if (k == 1) begin
            i_funct3 = 3'b001; i_addr = 32'h46; i_wdata = 32'h3456;
         end else begin
            i_req = 1'b0;
         end
      end
      repeat (5) @(negedge clk);
      chk("hold_writes", we_cnt - w0, 32'd3);
      chk("hold_word0", env_mem[16], 32'hAAAA_1255);
      chk("hold_word1", env_mem[17], 32'h3456_0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
